// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control sequencer: walks fetch/decode/execute/memory/writeback
// per instruction, handshakes with one shared memory, counts retired instructions.
module mips_multicycle_control #(
   parameter int OPCODE_W = 6,
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                alu_zero,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          alu_op,
   output logic [1:0]          pc_source,
   output logic [3:0]          state,
   output logic                illegal_op,
   output logic [RETIRE_W-1:0] retired
);

   // state    | meaning
   // FETCH    | read instruction at PC, PC += 4 when memory completes
   // DECODE   | read registers, precompute branch target into ALUOut
   // MEMADR   | effective address rs + imm for lw/sw
   // MEMRD    | data read, waits on mem_ready
   // MEMWB    | MDR -> rt
   // MEMWR    | data write, waits on mem_ready
   // RTYPE_EX | rs op rt under funct control
   // ALU_WB   | ALUOut -> rd
   // BRANCH   | compare rs - rt, load branch target if zero
   // JUMP     | load jump target
   // ADDI_EX  | rs + imm
   // ADDI_WB  | ALUOut -> rt
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      RTYPE_EX = 4'd6,
      ALU_WB   = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      ADDI_EX  = 4'd10,
      ADDI_WB  = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctl_t;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

   localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

   state_t cur;
   state_t nxt;
   ctl_t   ctl_q;
   logic   opcode_legal;
   logic   retire;

   function automatic ctl_t decode_ctl(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         DECODE: c.alu_src_b = 2'b11;
         MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         MEMRD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         MEMWB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         MEMWR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         RTYPE_EX: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
         end
         ALU_WB: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
         end
         BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 2'b01;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
         end
         JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
         end
         ADDI_EX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         ADDI_WB: c.reg_write = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      opcode_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                     (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);
   end

   always_comb begin
      nxt    = FETCH;
      retire = 1'b0;
      case (cur)
         FETCH:  nxt = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_RTYPE:      nxt = RTYPE_EX;
               OP_LW, OP_SW:  nxt = MEMADR;
               OP_BEQ:        nxt = BRANCH;
               OP_J:          nxt = JUMP;
               OP_ADDI:       nxt = ADDI_EX;
               default:       nxt = FETCH;
            endcase
         end
         MEMADR:   nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
         MEMRD:    nxt = mem_ready ? MEMWB : MEMRD;
         MEMWB: begin
            nxt    = FETCH;
            retire = 1'b1;
         end
         MEMWR: begin
            nxt    = mem_ready ? FETCH : MEMWR;
            retire = mem_ready;
         end
         RTYPE_EX: nxt = ALU_WB;
         ALU_WB, BRANCH, JUMP, ADDI_WB: begin
            nxt    = FETCH;
            retire = 1'b1;
         end
         ADDI_EX:  nxt = ADDI_WB;
         default:  nxt = FETCH;
      endcase
   end

   // Moore outputs are registered from the next state so they are glitch-free
   // the cycle the state is entered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cur        <= FETCH;
         ctl_q      <= decode_ctl(FETCH);
         retired    <= '0;
         illegal_op <= 1'b0;
      end else begin
         cur   <= nxt;
         ctl_q <= decode_ctl(nxt);
         if (cur == DECODE && !opcode_legal)
            illegal_op <= 1'b1;
         if (retire)
            retired <= retired + RETIRE_ONE;
      end
   end

   // Fetch completion (IR load, PC += 4) follows mem_ready in the same cycle;
   // every enable is held low while reset is asserted.
   always_comb begin
      pc_write      = rst & (ctl_q.pc_write | ((cur == FETCH) & mem_ready));
      ir_write      = rst & (cur == FETCH) & mem_ready;
      pc_write_cond = rst & ctl_q.pc_write_cond;
      mem_read      = rst & ctl_q.mem_read;
      mem_write     = rst & ctl_q.mem_write;
      reg_write     = rst & ctl_q.reg_write;
      i_or_d        = ctl_q.i_or_d;
      reg_dst       = ctl_q.reg_dst;
      mem_to_reg    = ctl_q.mem_to_reg;
      alu_src_a     = ctl_q.alu_src_a;
      alu_src_b     = ctl_q.alu_src_b;
      alu_op        = ctl_q.alu_op;
      pc_source     = ctl_q.pc_source;
      state         = cur;
   end

   logic unused_ok;
   assign unused_ok = alu_zero;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle MIPS sequencer; expected per-cycle outputs
// are queued when a cycle is driven and compared when that cycle is sampled.
module tb_mips_multicycle_control;

   logic        clk;
   logic        rst;
   logic [5:0]  opcode;
   logic        alu_zero;
   logic        mem_ready;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic [3:0]  state;
   logic        illegal_op;
   logic [31:0] retired;

   typedef struct {
      logic [3:0]  st;
      logic [15:0] ctl;
      logic        ill;
      logic [31:0] ret;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
   localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000, RT = 6'b000000, BAD = 6'b111111;

   mips_multicycle_control #(.OPCODE_W(6), .RETIRE_W(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .state(state), .illegal_op(illegal_op), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packing: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
   // reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
   function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic mr, input logic rv);
      logic pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, asa;
      logic [1:0] asb, aop, psrc;
      {pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, asa} = '0;
      asb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (st)
         4'd0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
         4'd1:  asb = 2'b11;
         4'd2:  begin asa = 1'b1; asb = 2'b10; end
         4'd3:  begin mrd = 1'b1; iod = 1'b1; end
         4'd4:  begin m2r = 1'b1; rw = 1'b1; end
         4'd5:  begin mwr = 1'b1; iod = 1'b1; end
         4'd6:  begin asa = 1'b1; aop = 2'b10; end
         4'd7:  begin rd = 1'b1; rw = 1'b1; end
         4'd8:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
         4'd9:  begin pw = 1'b1; psrc = 2'b10; end
         4'd10: begin asa = 1'b1; asb = 2'b10; end
         4'd11: rw = 1'b1;
         default: ;
      endcase
      if (!rv) {pw, pwc, mrd, mwr, irw, rw} = '0;
      return {pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, asa, asb, aop, psrc};
   endfunction

   // One clock cycle: drive inputs just after the edge, queue what this cycle
   // must show, then compare at the falling edge.
   task automatic cyc(input logic rv, input logic [5:0] op, input logic mr, input logic az,
                      input logic [3:0] st, input logic ill, input logic [31:0] ret);
      exp_t e, g;
      logic [15:0] act_ctl;
      @(posedge clk);
      #1;
      rst = rv; opcode = op; mem_ready = mr; alu_zero = az;
      e.st = st; e.ctl = exp_ctl(st, mr, rv); e.ill = ill; e.ret = ret;
      sb.push_back(e);
      @(negedge clk);
      total++;
      assert (sb.size() != 0) passed++;
      else $error("FAIL scoreboard_empty got=0 want=nonzero");
      if (sb.size() != 0) begin
         g = sb.pop_front();
         act_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
         total++;
         assert (state === g.st) passed++;
         else $error("FAIL state t=%0t got=%0d want=%0d", $time, state, g.st);
         total++;
         assert (act_ctl === g.ctl) passed++;
         else $error("FAIL ctl t=%0t st=%0d got=%b want=%b", $time, g.st, act_ctl, g.ctl);
         total++;
         assert (illegal_op === g.ill) passed++;
         else $error("FAIL illegal_op t=%0t got=%b want=%b", $time, illegal_op, g.ill);
         total++;
         assert (retired === g.ret) passed++;
         else $error("FAIL retired t=%0t got=%0d want=%0d", $time, retired, g.ret);
      end
   endtask

   initial begin
      rst = 1'b0; opcode = RT; mem_ready = 1'b0; alu_zero = 1'b0;
      // reset held two cycles
      cyc(0, RT,  1, 0, 0, 0, 0);
      cyc(0, RT,  1, 0, 0, 0, 0);
      // lw, zero-wait
      cyc(1, LW,  1, 0, 0, 0, 0);
      cyc(1, LW,  1, 0, 1, 0, 0);
      cyc(1, LW,  1, 0, 2, 0, 0);
      cyc(1, LW,  1, 0, 3, 0, 0);
      cyc(1, LW,  1, 0, 4, 0, 0);
      // sw with three wait cycles in MEMWR
      cyc(1, SW,  1, 0, 0, 0, 1);
      cyc(1, SW,  1, 0, 1, 0, 1);
      cyc(1, SW,  1, 0, 2, 0, 1);
      cyc(1, SW,  0, 0, 5, 0, 1);
      cyc(1, SW,  0, 0, 5, 0, 1);
      cyc(1, SW,  0, 0, 5, 0, 1);
      cyc(1, SW,  1, 0, 5, 0, 1);
      // beq taken, then j
      cyc(1, BEQ, 1, 1, 0, 0, 2);
      cyc(1, BEQ, 1, 1, 1, 0, 2);
      cyc(1, BEQ, 1, 1, 8, 0, 2);
      cyc(1, JMP, 1, 0, 0, 0, 3);
      cyc(1, JMP, 1, 0, 1, 0, 3);
      cyc(1, JMP, 1, 0, 9, 0, 3);
      // illegal opcode, then R-type
      cyc(1, BAD, 1, 0, 0, 0, 4);
      cyc(1, BAD, 1, 0, 1, 0, 4);
      cyc(1, RT,  1, 0, 0, 1, 4);
      cyc(1, RT,  1, 0, 1, 1, 4);
      cyc(1, RT,  1, 0, 6, 1, 4);
      cyc(1, RT,  1, 0, 7, 1, 4);
      // lw interrupted by reset while stalled in MEMRD
      cyc(1, LW,  1, 0, 0, 1, 5);
      cyc(1, LW,  1, 0, 1, 1, 5);
      cyc(1, LW,  1, 0, 2, 1, 5);
      cyc(1, LW,  0, 0, 3, 1, 5);
      cyc(0, LW,  0, 0, 3, 1, 5);
      cyc(1, LW,  0, 0, 0, 0, 0);
      // addi after reset, with one fetch wait cycle above
      cyc(1, ADDI, 1, 0, 0, 0, 0);
      cyc(1, ADDI, 1, 0, 1, 0, 0);
      cyc(1, ADDI, 1, 0, 10, 0, 0);
      cyc(1, ADDI, 1, 0, 11, 0, 0);
      cyc(1, RT,   0, 0, 0, 0, 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
